// File: rtl/conta_8b_counter.sv
// conta_8b_counter: enable-gated sawtooth up-counter for the DigitalPWM datapath.
// Counts 0..MAX_VAL, wraps to 0, and flags the last count with a terminal-count strobe.
module conta_8b_counter #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MAX_VAL = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic [WIDTH-1:0] F_out,
   output logic             tc
);

   // Largest value representable in WIDTH bits (wraps correctly at WIDTH = 32).
   localparam int unsigned C_FULL  = (32'd1 << WIDTH) - 32'd1;
   // Out-of-range MAX_VAL (zero or too wide) falls back to the full-scale ramp.
   localparam int unsigned C_MAX   = ((MAX_VAL == 32'd0) || (MAX_VAL > C_FULL)) ? C_FULL : MAX_VAL;
   localparam logic [WIDTH-1:0] C_MAX_W = WIDTH'(C_MAX);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_at_max;
   logic             w_past_max;

   // Terminal and overrange detection on the registered count.
   always_comb begin
      w_at_max   = (r_count == C_MAX_W);
      w_past_max = (r_count >  C_MAX_W);
   end

   // Next count: hold when disabled, wrap at (or beyond) the terminal value.
   always_comb begin
      w_count_nxt = r_count;
      if (enable) begin
         if (w_at_max || w_past_max) begin
            w_count_nxt = '0;
         end else begin
            w_count_nxt = r_count + WIDTH'(1);
         end
      end
   end

   // Count register; reset clears it immediately and outranks enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
      end
   end

   assign F_out = r_count;
   // Strobe is intentionally combinational so it lines up with the terminal count.
   assign tc    = enable & w_at_max;

endmodule

// File: tb/tb_conta_8b_counter.sv
// Self-checking bench for conta_8b_counter: directed table, multi-cycle corner
// sequences and randomized enable/reset against a modulo-arithmetic reference.
module tb_conta_8b_counter;

   localparam int W    = 8;
   localparam int MAXV = 255;

   logic         clk;
   logic         reset;
   logic         enable;
   logic [W-1:0] F_out;
   logic         tc;

   int checks   = 0;
   int failures = 0;
   int m        = 0;   // reference count

   conta_8b_counter #(.WIDTH(W), .MAX_VAL(MAXV)) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .F_out  (F_out),
      .tc     (tc)
   );

   initial begin
      clk = 1'b0;
      forever #100 clk = ~clk;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic en;
      int   n_edges;
      int   exp_count;
      logic exp_tc;
   } vec_t;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // One rising edge; reference follows the counting rules, then settle.
   task automatic tick();
      @(posedge clk);
      if (reset)       m = 0;
      else if (enable) m = (m + 1) % (MAXV + 1);
      #1;
   endtask

   task automatic check_model(input string name);
      check({name, "_count"}, int'(F_out), m);
      check({name, "_tc"}, int'(tc), int'(enable && (m == MAXV)));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   vec_t vecs[6];
   int   tc_seen;

   initial begin
      vecs[0] = '{1'b1,   5,   5, 1'b0};
      vecs[1] = '{1'b1, 250, 255, 1'b1};
      vecs[2] = '{1'b1,   1,   0, 1'b0};
      vecs[3] = '{1'b1, 100, 100, 1'b0};
      vecs[4] = '{1'b0,  20, 100, 1'b0};
      vecs[5] = '{1'b1,   1, 101, 1'b0};

      // Power-up, then asynchronous reset without an edge.
      reset  = 1'b0;
      enable = 1'b0;
      #150;
      reset = 1'b1;
      #1;
      check("async_reset_count", int'(F_out), 0);
      check("async_reset_tc", int'(tc), 0);
      m = 0;
      tick();
      check("reset_edge_count", int'(F_out), 0);
      check("reset_edge_tc", int'(tc), 0);
      reset = 1'b0;

      // Hold with enable low.
      for (int i = 0; i < 10; i++) tick();
      check("hold_count", int'(F_out), 0);

      // Directed table: count, terminal, wrap, pause, resume.
      for (int v = 0; v < 6; v++) begin
         enable = vecs[v].en;
         for (int e = 0; e < vecs[v].n_edges; e++) tick();
         check($sformatf("vec%0d_count", v), int'(F_out), vecs[v].exp_count);
         check($sformatf("vec%0d_tc", v), int'(tc), int'(vecs[v].exp_tc));
      end

      // Full 1024-edge run with terminal-count census.
      enable = 1'b0;
      do_reset();
      enable  = 1'b1;
      tc_seen = 0;
      for (int e = 0; e < 1024; e++) begin
         tick();
         check_model($sformatf("run_e%0d", e + 1));
         if (tc) tc_seen++;
      end
      check("run_end_count", int'(F_out), 0);
      check("run_tc_total", tc_seen, 4);

      // Asynchronous reset between edges at count 77.
      enable = 1'b0;
      do_reset();
      enable = 1'b1;
      for (int e = 0; e < 77; e++) tick();
      check("pre_async_count", int'(F_out), 77);
      #50;
      reset = 1'b1;
      #1;
      m = 0;
      check("mid_async_count", int'(F_out), 0);
      #10;
      reset = 1'b0;
      tick();
      check_model("post_async");

      // Reset and enable both high at an edge.
      reset  = 1'b1;
      enable = 1'b1;
      tick();
      check("rst_en_count", int'(F_out), 0);
      reset = 1'b0;

      // Randomized enable with occasional synchronous-edge or mid-cycle resets.
      for (int i = 0; i < 900; i++) begin
         enable = ($urandom_range(0, 7) != 0);
         reset  = ($urandom_range(0, 99) == 0);
         tick();
         check_model($sformatf("rand%0d", i));
         reset = 1'b0;
         if ($urandom_range(0, 149) == 0) begin
            #40;
            reset = 1'b1;
            #1;
            m = 0;
            check($sformatf("rand_async%0d", i), int'(F_out), 0);
            reset = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
